// File: rtl/amiga_a1000_wom_ctrl_if.sv
// CPU-side bus bundle for the A1000 ROM/WOM sequencer.
// The controller is the slave; the 68000 side (or a testbench) is the master.
interface amiga_a1000_wom_ctrl_if;
    // CPU address and strobes (strobes active low, asynchronous to the bus clock)
    logic [23:1] a;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        prw;        // 1 = read, 0 = write
    logic        ovl;        // boot ROM overlay at 000000
    logic        ovr_n;      // 0 = external override, nothing decodes
    logic        xrdy;       // 0 = stretch the cycle
    logic        dbr_n;      // 0 = DMA owns the bus
    logic        j1_enable;  // 1 = WOM writes permitted at all

    // Memory-side and handshake outputs
    logic        dtack_n;
    logic        dtack_oe;
    logic        rome_n;
    logic        wome_n;
    logic        womoe_n;
    logic        womwe_u_n;
    logic        womwe_l_n;
    logic        wprot;

    modport master (
        output a, as_n, uds_n, lds_n, prw, ovl, ovr_n, xrdy, dbr_n, j1_enable,
        input  dtack_n, dtack_oe, rome_n, wome_n, womoe_n, womwe_u_n, womwe_l_n, wprot
    );

    modport slave (
        input  a, as_n, uds_n, lds_n, prw, ovl, ovr_n, xrdy, dbr_n, j1_enable,
        output dtack_n, dtack_oe, rome_n, wome_n, womoe_n, womwe_u_n, womwe_l_n, wprot
    );
endinterface

// File: rtl/amiga_a1000_wom_ctrl.sv
// Bus-cycle sequencer for the A1000 boot ROM and 256 KB writable-once memory.
// Decodes 68000 cycles, drives chip selects / write strobes, generates DTACK
// and owns the one-way WOM write-protect latch.
module amiga_a1000_wom_ctrl #(
    parameter logic [3:0] WAIT_STATES = 4'd2
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    amiga_a1000_wom_ctrl_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_e;

    typedef enum logic [1:0] {
        R_NONE,
        R_BOOT,
        R_WOM,
        R_LOCK
    } region_e;

    logic [1:0] as_sync_q;
    logic [1:0] uds_sync_q;
    logic [1:0] lds_sync_q;
    logic       s_as;
    logic       s_uds;
    logic       s_lds;

    state_e     state_q,    state_d;
    logic [3:0] cnt_q,      cnt_d;
    region_e    region_q,   region_d;
    logic       read_q,     read_d;
    logic       wprot_q,    wprot_d;
    logic       rome_n_q,   rome_n_d;
    logic       wome_n_q,   wome_n_d;
    logic       womoe_n_q,  womoe_n_d;
    logic       we_u_n_q,   we_u_n_d;
    logic       we_l_n_q,   we_l_n_d;
    logic       dtack_oe_q, dtack_oe_d;
    logic       dtack_n_q,  dtack_n_d;

    region_e    region_dec;
    logic       active;
    logic       we_ok;

    // Only A[23:18] take part in the decode; the rest belongs to the memories.
    logic       unused_addr;
    assign unused_addr = ^bus.a[17:1];

    assign s_as  = as_sync_q[1];
    assign s_uds = uds_sync_q[1];
    assign s_lds = lds_sync_q[1];

    // Two-flop synchronizers for the asynchronous CPU strobes (idle = high).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            as_sync_q  <= 2'b11;
            uds_sync_q <= 2'b11;
            lds_sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous
            // stage's old value, which is what turns this into a real 2-stage chain.
            as_sync_q  <= {as_sync_q[0],  bus.as_n};
            uds_sync_q <= {uds_sync_q[0], bus.uds_n};
            lds_sync_q <= {lds_sync_q[0], bus.lds_n};
        end
    end

    // Address decode of the live CPU address; only captured in DECODE.
    always_comb begin
        // NOTE: assigning a default before any branch keeps this purely
        // combinational; a path that skips the assignment would infer a latch.
        region_dec = R_NONE;
        if (bus.a[23:18] == 6'b111111) begin
            region_dec = R_WOM;
        end else if ((bus.a[23:18] == 6'b111110) ||
                     (bus.ovl && (bus.a[23:18] == 6'b000000))) begin
            region_dec = R_BOOT;
        end else if (bus.a[23:18] == 6'b111001) begin
            region_dec = R_LOCK;
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        region_d = region_q;
        read_d   = read_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (!s_as) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (s_as) begin
                    state_d = S_IDLE;
                end else begin
                    region_d = region_dec;
                    read_d   = bus.prw;
                    // Overridden, unmapped or ROM-write cycles are left for someone else.
                    if (!bus.ovr_n || (region_dec == R_NONE) ||
                        ((region_dec == R_BOOT) && !bus.prw)) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_STATES;
                    end
                end
            end
            S_WAIT: begin
                if (s_as) begin
                    state_d = S_IDLE;
                end else if (bus.xrdy && bus.dbr_n) begin
                    if (cnt_q == 4'd0) state_d = S_ACK;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            S_ACK, S_HOLD: begin
                if (s_as) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Selects follow the state being entered so they are registered with it.
        active = (state_d == S_WAIT) || (state_d == S_ACK);
        we_ok  = active && (region_d == R_WOM) && !read_d && bus.j1_enable && !wprot_q;

        rome_n_d   = !(active && (region_d == R_BOOT));
        wome_n_d   = !(active && (region_d == R_WOM));
        womoe_n_d  = !(active && (region_d == R_WOM) && read_d);
        we_u_n_d   = we_ok ? s_uds : 1'b1;
        we_l_n_d   = we_ok ? s_lds : 1'b1;
        dtack_oe_d = (state_d == S_ACK);
        dtack_n_d  = !dtack_oe_d;

        // The lock is one-way: a completed write to the LOCK window sets it.
        wprot_d = wprot_q ||
                  ((state_q == S_WAIT) && (state_d == S_ACK) &&
                   (region_q == R_LOCK) && !read_q);
    end

    // State, counter, captured cycle attributes and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            region_q   <= R_NONE;
            read_q     <= 1'b1;
            wprot_q    <= 1'b0;
            rome_n_q   <= 1'b1;
            wome_n_q   <= 1'b1;
            womoe_n_q  <= 1'b1;
            we_u_n_q   <= 1'b1;
            we_l_n_q   <= 1'b1;
            dtack_oe_q <= 1'b0;
            dtack_n_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            region_q   <= region_d;
            read_q     <= read_d;
            wprot_q    <= wprot_d;
            rome_n_q   <= rome_n_d;
            wome_n_q   <= wome_n_d;
            womoe_n_q  <= womoe_n_d;
            we_u_n_q   <= we_u_n_d;
            we_l_n_q   <= we_l_n_d;
            dtack_oe_q <= dtack_oe_d;
            dtack_n_q  <= dtack_n_d;
        end
    end

    assign bus.rome_n    = rome_n_q;
    assign bus.wome_n    = wome_n_q;
    assign bus.womoe_n   = womoe_n_q;
    assign bus.womwe_u_n = we_u_n_q;
    assign bus.womwe_l_n = we_l_n_q;
    assign bus.dtack_oe  = dtack_oe_q;
    assign bus.dtack_n   = dtack_n_q;
    assign bus.wprot     = wprot_q;

endmodule

// File: tb/tb_amiga_a1000_wom_ctrl.sv
// Directed bench for the A1000 ROM/WOM sequencer with a small scoreboard.
// Output vector layout: {dtack_oe, rome_n, wome_n, womoe_n, womwe_u_n, womwe_l_n}.
module tb_amiga_a1000_wom_ctrl;

    logic clk;
    logic rst_n;

    amiga_a1000_wom_ctrl_if bus ();

    amiga_a1000_wom_ctrl #(.WAIT_STATES(4'd2)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [5:0] sel4;   // vector after edge 4
        int         dt;     // edge of first DTACK, 0 = never
        logic [5:0] pre;    // vector at the edge _AS is released after
        logic       wp;     // WPROT at end of cycle
    } exp_t;

    localparam logic [5:0] IDLE_V = 6'b011111;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] vec();
        return {bus.dtack_oe, bus.rome_n, bus.wome_n, bus.womoe_n, bus.womwe_u_n, bus.womwe_l_n};
    endfunction

    // One CPU cycle. _AS (and strobes) go low just before edge 1; XRDY/_DBR are
    // pulled low for xs/ds edges starting at edge 5; _AS is released after the
    // DTACK edge, after edge ab (if nonzero), or after edge 14 if no DTACK comes.
    task automatic run_cycle(input string tag, input logic [23:0] ba, input logic rd,
                             input logic [1:0] ul, input int xs, input int ds, input int ab,
                             input logic [5:0] e4, input int edt, input logic [5:0] epre,
                             input logic ewp);
        exp_t       e;
        logic [5:0] obs3, obs4, pre, rel2, rel3;
        int         dt;
        int         rel_at;
        sb.push_back('{tag: tag, sel4: e4, dt: edt, pre: epre, wp: ewp});
        obs3 = 'x; obs4 = 'x; pre = 'x; rel2 = 'x; rel3 = 'x;
        dt = 0;
        rel_at = -1;
        @(negedge clk);
        bus.a     = ba[23:1];
        bus.prw   = rd;
        bus.uds_n = ul[1];
        bus.lds_n = ul[0];
        bus.as_n  = 1'b0;
        bus.xrdy  = 1'b1;
        bus.dbr_n = 1'b1;
        for (int ed = 1; ed <= 30; ed++) begin
            @(posedge clk);
            #1;
            if (bus.dtack_oe) begin
                check({tag, "_dtack_n"}, bus.dtack_n, 1'b0);
                if (dt == 0) dt = ed;
            end
            if (ed == 3) obs3 = vec();
            if (ed == 4) obs4 = vec();
            if (rel_at < 0 && ((ab != 0 && ed == ab) || (ab == 0 && (dt != 0 || ed == 14)))) begin
                pre    = vec();
                rel_at = ed;
            end
            if (rel_at > 0 && ed == rel_at + 2) rel2 = vec();
            if (rel_at > 0 && ed == rel_at + 3) begin
                rel3 = vec();
                break;
            end
            @(negedge clk);
            if (rel_at > 0) begin
                bus.as_n  = 1'b1;
                bus.uds_n = 1'b1;
                bus.lds_n = 1'b1;
            end
            bus.xrdy  = !((ed + 1 >= 5) && (ed + 1 < 5 + xs));
            bus.dbr_n = !((ed + 1 >= 5) && (ed + 1 < 5 + ds));
        end
        e = sb.pop_front();
        check({e.tag, "_edge3"}, obs3, IDLE_V);
        check({e.tag, "_edge4"}, obs4, e.sel4);
        check({e.tag, "_dtack_edge"}, dt, e.dt);
        check({e.tag, "_pre_release"}, pre, e.pre);
        check({e.tag, "_release2"}, rel2, e.pre);
        check({e.tag, "_release3"}, rel3, IDLE_V);
        check({e.tag, "_wprot"}, bus.wprot, e.wp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ba;
        rst_n         = 1'b0;
        bus.a         = '0;
        bus.as_n      = 1'b1;
        bus.uds_n     = 1'b1;
        bus.lds_n     = 1'b1;
        bus.prw       = 1'b1;
        bus.ovl       = 1'b1;
        bus.ovr_n     = 1'b1;
        bus.xrdy      = 1'b1;
        bus.dbr_n     = 1'b1;
        bus.j1_enable = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_vec", vec(), IDLE_V);
        check("reset_dtack_n", bus.dtack_n, 1'b1);
        check("reset_wprot", bus.wprot, 1'b0);
        rst_n = 1'b1;

        // Overlay boot ROM read at 000000.
        run_cycle("ovl_rom_rd", 24'h000000, 1'b1, 2'b00, 0, 0, 0, 6'b001111, 7, 6'b101111, 1'b0);
        // Overlay off: 000000 maps nothing.
        bus.ovl = 1'b0;
        run_cycle("noovl_rd", 24'h000000, 1'b1, 2'b00, 0, 0, 0, IDLE_V, 0, IDLE_V, 1'b0);
        run_cycle("rom_rd", 24'hF80000, 1'b1, 2'b00, 0, 0, 0, 6'b001111, 7, 6'b101111, 1'b0);
        // WOM write, both lanes.
        run_cycle("wom_wr", 24'hFC0000, 1'b0, 2'b00, 0, 0, 0, 6'b010100, 7, 6'b110100, 1'b0);
        // Upper lane only.
        run_cycle("wom_wr_u", 24'hFC0002, 1'b0, 2'b01, 0, 0, 0, 6'b010101, 7, 6'b110101, 1'b0);
        // LOCK read has no effect; LOCK write sets the protect latch.
        run_cycle("lock_rd", 24'hE40000, 1'b1, 2'b00, 0, 0, 0, IDLE_V, 7, 6'b111111, 1'b0);
        run_cycle("lock_wr", 24'hE40000, 1'b0, 2'b00, 0, 0, 0, IDLE_V, 7, 6'b111111, 1'b1);
        // Protected WOM write: acknowledged, strobes stay high.
        run_cycle("wom_wr_prot", 24'hFC0000, 1'b0, 2'b00, 0, 0, 0, 6'b010111, 7, 6'b110111, 1'b1);
        // Wait-state stretching.
        run_cycle("xrdy_stall", 24'hFC0000, 1'b1, 2'b00, 4, 0, 0, 6'b010011, 11, 6'b110011, 1'b1);
        run_cycle("dbr_stall", 24'hFC0000, 1'b1, 2'b00, 0, 2, 0, 6'b010011, 9, 6'b110011, 1'b1);
        // External override and ROM write.
        bus.ovr_n = 1'b0;
        run_cycle("ovr_wom_rd", 24'hFC0000, 1'b1, 2'b00, 0, 0, 0, IDLE_V, 0, IDLE_V, 1'b1);
        run_cycle("ovr_rom_wr", 24'hF80000, 1'b0, 2'b00, 0, 0, 0, IDLE_V, 0, IDLE_V, 1'b1);
        bus.ovr_n = 1'b1;
        run_cycle("rom_wr", 24'hF80000, 1'b0, 2'b00, 0, 0, 0, IDLE_V, 0, IDLE_V, 1'b1);
        // _AS released while stretched in WAIT.
        run_cycle("abort_wait", 24'hFC0000, 1'b1, 2'b00, 12, 0, 5, 6'b010011, 0, 6'b010011, 1'b1);

        // Reset pulse in the middle of a WOM read with the latch set.
        ba = 24'hFC0000;
        @(negedge clk);
        bus.a     = ba[23:1];
        bus.prw   = 1'b1;
        bus.uds_n = 1'b0;
        bus.lds_n = 1'b0;
        bus.as_n  = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("midrst_before_vec", vec(), 6'b010011);
        check("midrst_before_wprot", bus.wprot, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_vec", vec(), IDLE_V);
        check("midrst_dtack_n", bus.dtack_n, 1'b1);
        check("midrst_wprot", bus.wprot, 1'b0);
        @(negedge clk);
        bus.as_n  = 1'b1;
        bus.uds_n = 1'b1;
        bus.lds_n = 1'b1;
        rst_n     = 1'b1;
        repeat (3) @(posedge clk);

        // Latch cleared: writes land again; then J1 disables them.
        run_cycle("wom_wr_after_rst", 24'hFC0000, 1'b0, 2'b00, 0, 0, 0, 6'b010100, 7, 6'b110100, 1'b0);
        bus.j1_enable = 1'b0;
        run_cycle("wom_wr_j1_off", 24'hFC0000, 1'b0, 2'b00, 0, 0, 0, 6'b010111, 7, 6'b110111, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
